// File: rtl/instr_fetch_stage.sv
// RV32I instruction fetch stage: PC register, IF/ID slot and decode handshake.
// Define FETCH_MISALIGN_CHK_EN to trap on misaligned redirect targets.
module instr_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        fetch_misalign
`endif
);

  // state | meaning
  // BOOT  | first cycle after reset, no capture
  // RUN   | fetching and handing slots to decode
  // TRAP  | misaligned redirect seen; frozen until reset
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] plus4_q, plus4_d;
  logic        misalign_q, misalign_d;
  logic        advance;

  assign advance = (state_q == RUN) && (!valid_q || id_ready);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    id_pc_d    = id_pc_q;
    instr_d    = instr_q;
    plus4_d    = plus4_q;
    misalign_d = misalign_q;

    if (redirect_valid && (state_q != TRAP)) begin
      // Flush wins over any capture; a slot handed over this cycle still counts as consumed.
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      state_d = RUN;
`ifdef FETCH_MISALIGN_CHK_EN
      pc_d = redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        state_d    = TRAP;
        misalign_d = 1'b1;
      end
`else
      pc_d = redirect_pc & 32'hFFFF_FFFC;
`endif
    end else if (state_q == BOOT) begin
      state_d = RUN;
    end else if (advance) begin
      id_pc_d = pc_q;
      instr_d = imem_instr;
      plus4_d = pc_q + 32'd4;
      valid_d = 1'b1;
      pc_d    = pc_q + 32'd4;
    end else if (valid_q && id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      valid_q    <= 1'b0;
      id_pc_q    <= 32'h0;
      instr_q    <= NOP_INSTR;
      plus4_q    <= 32'h0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      id_pc_q    <= id_pc_d;
      instr_q    <= instr_d;
      plus4_q    <= plus4_d;
      misalign_q <= misalign_d;
    end
  end

  assign imem_pc     = pc_q;
  assign id_valid    = valid_q;
  assign id_pc       = id_pc_q;
  assign id_instr    = instr_q;
  assign id_pc_plus4 = plus4_q;

`ifdef FETCH_MISALIGN_CHK_EN
  assign fetch_misalign = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed scenarios plus a random
// phase checked every cycle against a transaction-level fetch model.
module tb_instr_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_pc, imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_pc, id_instr, id_pc_plus4;
  logic        fetch_misalign;

  logic        rst2_n;
  logic [31:0] imem_pc2, imem_instr2;
  logic        id_valid2;
  logic [31:0] id_pc2, id_instr2, id_pc_plus4_2;
  logic        fetch_misalign2;

  logic [31:0] imem [64];

  int checks = 0;
  int errors = 0;

  // model of the fetch stage: next fetch address plus the decode slot
  logic [31:0] m_pc, m_idpc, m_instr, m_plus4;
  logic        m_valid, m_boot, m_trap, m_mis;

  always #5 clk = ~clk;

  assign imem_instr  = imem[imem_pc[7:2]];
  assign imem_instr2 = imem[imem_pc2[7:2]];

  instr_fetch_stage u_dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign)
`endif
  );

  instr_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst_n(rst2_n), .imem_pc(imem_pc2), .imem_instr(imem_instr2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .id_valid(id_valid2), .id_ready(1'b1), .id_pc(id_pc2),
    .id_instr(id_instr2), .id_pc_plus4(id_pc_plus4_2)
`ifdef FETCH_MISALIGN_CHK_EN
    , .fetch_misalign(fetch_misalign2)
`endif
  );

`ifndef FETCH_MISALIGN_CHK_EN
  assign fetch_misalign  = 1'b0;
  assign fetch_misalign2 = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [31:0] fetched;
    fetched = imem[m_pc[7:2]];
    if (!rst_n) begin
      m_pc = 32'h0; m_boot = 1'b1; m_trap = 1'b0; m_valid = 1'b0;
      m_idpc = 32'h0; m_instr = NOP; m_plus4 = 32'h0; m_mis = 1'b0;
    end else if (redirect_valid && !m_trap) begin
      m_valid = 1'b0;
      m_instr = NOP;
      m_boot  = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
      m_pc = redirect_pc;
      if (redirect_pc % 4 != 0) begin
        m_trap = 1'b1;
        m_mis  = 1'b1;
      end
`else
      m_pc = redirect_pc - (redirect_pc % 4);
`endif
    end else if (m_boot) begin
      m_boot = 1'b0;
    end else if (!m_trap && (!m_valid || id_ready)) begin
      m_idpc  = m_pc;
      m_instr = fetched;
      m_plus4 = m_pc + 4;
      m_valid = 1'b1;
      m_pc    = m_pc + 4;
    end
  endtask

  task automatic compare_model();
    check("imem_pc", imem_pc, m_pc);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
    if (m_valid) begin
      check("id_pc", id_pc, m_idpc);
      check("id_instr", id_instr, m_instr);
      check("id_pc_plus4", id_pc_plus4, m_plus4);
    end
`ifdef FETCH_MISALIGN_CHK_EN
    check("fetch_misalign", {31'b0, fetch_misalign}, {31'b0, m_mis});
`endif
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_model();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = $urandom;
    imem[0] = 32'h0000_0013; imem[1] = 32'h0050_0093; imem[2] = 32'h0060_0113;
    imem[3] = 32'h0020_81B3; imem[4] = 32'h0031_0023; imem[5] = 32'h0000_8067;

    rst_n = 1'b0; rst2_n = 1'b0; id_ready = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    m_pc = 32'h0; m_idpc = 32'h0; m_instr = NOP; m_plus4 = 32'h0;
    m_valid = 1'b0; m_boot = 1'b1; m_trap = 1'b0; m_mis = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("rst_imem_pc", imem_pc, 32'h0);
    check("rst_id_valid", {31'b0, id_valid}, 32'h0);
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'h0);
    check("rst_wrap_pc", imem_pc2, 32'hFFFF_FFFC);

    // release reset: BOOT cycle, then 0 and 4
    rst_n = 1'b1; rst2_n = 1'b1;
    tick();
    check("boot_no_valid", {31'b0, id_valid}, 32'h0);
    tick();
    check("first_pc", id_pc, 32'h0);
    check("first_instr", id_instr, 32'h0000_0013);
    check("first_valid", {31'b0, id_valid}, 32'h1);
    check("wrap_pc0", id_pc2, 32'hFFFF_FFFC);
    check("wrap_plus4", id_pc_plus4_2, 32'h0);
    tick();
    check("second_pc", id_pc, 32'h4);
    check("second_instr", id_instr, 32'h0050_0093);
    check("wrap_pc1", id_pc2, 32'h0);
    check("wrap_instr1", id_instr2, 32'h0000_0013);

    // stall three cycles at id_pc=4
    id_ready = 1'b0;
    tick();
    check("wrap_pc2", id_pc2, 32'h4);
    check("wrap_instr2", id_instr2, 32'h0050_0093);
    tick(); tick();
    check("stall_pc", id_pc, 32'h4);
    check("stall_imem_pc", imem_pc, 32'h8);
    id_ready = 1'b1;
    tick();
    check("after_stall_pc", id_pc, 32'h8);
    check("after_stall_instr", id_instr, 32'h0060_0113);

    // redirect to 0x14 while stalled
    id_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h14;
    tick();
    check("flush_valid", {31'b0, id_valid}, 32'h0);
    check("flush_imem_pc", imem_pc, 32'h14);
    check("flush_instr", id_instr, NOP);
    redirect_valid = 1'b0; id_ready = 1'b1;
    tick();
    check("redir_pc", id_pc, 32'h14);
    check("redir_instr", id_instr, 32'h0000_8067);
    check("redir_plus4", id_pc_plus4, 32'h18);

    // mid-run reset with imem_pc=0x0C
    redirect_valid = 1'b1; redirect_pc = 32'h0C;
    tick();
    redirect_valid = 1'b0; rst_n = 1'b0;
    tick();
    check("mid_rst_imem_pc", imem_pc, 32'h0);
    check("mid_rst_valid", {31'b0, id_valid}, 32'h0);
    check("mid_rst_instr", id_instr, NOP);
    rst_n = 1'b1;
    tick(); tick();
    check("resume_pc", id_pc, 32'h0);

    // redirect to a misaligned target
    redirect_valid = 1'b1; redirect_pc = 32'h16;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    check("mis_flag", {31'b0, fetch_misalign}, 32'h1);
    redirect_valid = 1'b1; redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    tick(); tick();
    check("trap_valid", {31'b0, id_valid}, 32'h0);
    check("trap_pc", imem_pc, 32'h16);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("trap_exit_flag", {31'b0, fetch_misalign}, 32'h0);
`else
    check("mis_imem_pc", imem_pc, 32'h14);
    tick();
    check("mis_instr", id_instr, 32'h0000_8067);
    check("mis_pc", id_pc, 32'h14);
`endif

    // random phase
    for (int n = 0; n < 3000; n++) begin
      id_ready       = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = $urandom_range(0, 255);
      rst_n          = ($urandom_range(0, 99) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
